reaction_timer_fsm: RTL and testbench

Reaction-time tester FSM for the Nexys4 DDR board. A start button arms a fixed preparation delay, then all LEDs light as the stimulus. A 4-digit BCD millisecond counter runs until the reaction button is pressed, and the result is multiplexed onto the right four seven-segment digits. All logic runs on one clock; a 1 kHz square wave enters as a sampled data input, not as a clock.

---
 rtl/reaction_timer_fsm_pkg.sv | 79 +++++++
 rtl/reaction_timer_fsm_if.sv | 34 +++
 rtl/ssd_mux4.sv | 44 ++++
 rtl/reaction_timer_fsm.sv | 133 +++++++++++++
 tb/tb_reaction_timer_fsm.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_timer_fsm_pkg.sv
// Shared types, constants and helpers for the reaction timer.
// State codes, LED patterns, BCD increment and 7-seg decode.
package reaction_timer_fsm_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PREP   = 4'd1,
    TIMING = 4'd2,
    DONE   = 4'd3,
    EARLY  = 4'd4
  } state_t;

  localparam logic [15:0] LED_OFF   = 16'h0000;
  localparam logic [15:0] LED_ON    = 16'hFFFF;
  localparam logic [15:0] LED_EARLY = 16'hAAAA;
  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [15:0] BCD_LAST  = 16'h9998;

  function automatic logic [15:0] led_of(
    input state_t s
  );
    logic [15:0] r;
    case (s)
      TIMING:  r = LED_ON;
      EARLY:   r = LED_EARLY;
      default: r = LED_OFF;
    endcase
    return r;
  endfunction

  // Four-digit BCD increment that saturates at 9999.
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        cy;
    r  = v;
    cy = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (cy) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(
    input logic [3:0] v
  );
    logic [6:0] r;
    case (v)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0010000;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;
      4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reaction_timer_fsm_if.sv
// Board-side signal bundle of the reaction timer.
// master drives buttons and dclk; slave is the timer.
interface reaction_timer_fsm_if;
  logic        dclk;
  logic        idletoPrep;
  logic        testmodeBtn;
  logic [15:0] led;
  logic [7:0]  ssdAnode;
  logic [6:0]  ssdCathode;
  logic [3:0]  state;
  logic [3:0]  nextState;
  logic [31:0] prepCounter;
  logic [3:0]  counter_a;
  logic [3:0]  counter_b;
  logic [3:0]  counter_c;
  logic [3:0]  counter_d;
  logic        clk_1Hzt;

  modport master (
    output dclk, idletoPrep, testmodeBtn,
    input  led, ssdAnode, ssdCathode,
    input  state, nextState, prepCounter,
    input  counter_a, counter_b,
    input  counter_c, counter_d, clk_1Hzt
  );

  modport slave (
    input  dclk, idletoPrep, testmodeBtn,
    output led, ssdAnode, ssdCathode,
    output state, nextState, prepCounter,
    output counter_a, counter_b,
    output counter_c, counter_d, clk_1Hzt
  );
endinterface

// File: rtl/ssd_mux4.sv
// Four-digit 7-seg multiplexer; digit index steps on each ms tick.
// Anodes and segments are active-low; upper four anodes stay off.
module ssd_mux4
  import reaction_timer_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] dig_a,
  input  logic [3:0] dig_b,
  input  logic [3:0] dig_c,
  input  logic [3:0] dig_d,
  output logic [7:0] anode,
  output logic [6:0] cathode
);

  logic [1:0] idx_q;
  logic [3:0] digit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 2'd0;
    end else if (tick) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  always_comb begin
    anode = 8'hFF;
    digit = dig_a;
    unique case (idx_q)
      2'd0: begin anode = 8'hFE; digit = dig_a; end
      2'd1: begin anode = 8'hFD; digit = dig_b; end
      2'd2: begin anode = 8'hFB; digit = dig_c; end
      default: begin
        anode = 8'hF7;
        digit = dig_d;
      end
    endcase
  end

  assign cathode = seg_decode(digit);

endmodule

// File: rtl/reaction_timer_fsm.sv
// Reaction-time tester: prep delay, LED stimulus, BCD ms count.
// One clock; dclk and both buttons are sampled data inputs.
module reaction_timer_fsm
  import reaction_timer_fsm_pkg::*;
#(
  parameter int unsigned PREP_CYCLES = 40_000_000,
  parameter int unsigned HZ_DIV      = 500
) (
  input logic                 clk,
  input logic                 reset,
  reaction_timer_fsm_if.slave bus
);

  logic [2:0]  raw, s1, s2, s3, re;
  logic        ms_tick, start_re, react_re;
  state_t      state_q, nxt;
  logic [31:0] prep_q;
  logic [15:0] bcd_q;
  logic [15:0] led_q;
  logic [31:0] hz_q;
  logic        hz_out_q;
  logic        prep_done;

  assign raw = {bus.testmodeBtn, bus.idletoPrep, bus.dclk};

  // Two sync flops, one history flop, registered rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      re <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
      re <= s2 & ~s3;
    end
  end

  assign ms_tick  = re[0];
  assign start_re = re[1];
  assign react_re = re[2];

  assign prep_done = (prep_q == 32'(PREP_CYCLES - 1));

  always_comb begin
    nxt = IDLE;
    case (state_q)
      IDLE: nxt = start_re ? PREP : IDLE;
      PREP: begin
        if (react_re)       nxt = EARLY;
        else if (prep_done) nxt = TIMING;
        else                nxt = PREP;
      end
      TIMING: begin
        if (react_re)
          nxt = DONE;
        else if (ms_tick && bcd_q == BCD_LAST)
          nxt = DONE;
        else
          nxt = TIMING;
      end
      DONE:    nxt = start_re ? PREP : DONE;
      EARLY:   nxt = start_re ? PREP : EARLY;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prep_q  <= '0;
      bcd_q   <= '0;
      led_q   <= LED_OFF;
    end else begin
      state_q <= nxt;
      led_q   <= led_of(nxt);
      if (state_q == PREP && nxt == PREP)
        prep_q <= prep_q + 32'd1;
      unique case (1'b1)
        (nxt == PREP && state_q != PREP): begin
          prep_q <= '0;
          bcd_q  <= '0;
        end
        (state_q == PREP && nxt == TIMING):
          bcd_q <= '0;
        (nxt == EARLY):
          bcd_q <= BCD_MAX;
        (state_q == TIMING && ms_tick && !react_re):
          bcd_q <= bcd_inc(bcd_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hz_q     <= '0;
      hz_out_q <= 1'b0;
    end else if (ms_tick) begin
      if (hz_q == 32'(HZ_DIV - 1)) begin
        hz_q     <= '0;
        hz_out_q <= ~hz_out_q;
      end else begin
        hz_q <= hz_q + 32'd1;
      end
    end
  end

  ssd_mux4 u_ssd (
    .clk     (clk),
    .reset   (reset),
    .tick    (ms_tick),
    .dig_a   (bcd_q[3:0]),
    .dig_b   (bcd_q[7:4]),
    .dig_c   (bcd_q[11:8]),
    .dig_d   (bcd_q[15:12]),
    .anode   (bus.ssdAnode),
    .cathode (bus.ssdCathode)
  );

  assign bus.led         = led_q;
  assign bus.state       = state_q;
  assign bus.nextState   = nxt;
  assign bus.prepCounter = prep_q;
  assign bus.counter_a   = bcd_q[3:0];
  assign bus.counter_b   = bcd_q[7:4];
  assign bus.counter_c   = bcd_q[11:8];
  assign bus.counter_d   = bcd_q[15:12];
  assign bus.clk_1Hzt    = hz_out_q;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Scoreboarded bench: every state change is checked against a
// queue filled by the stimulus from a cycle-count reference model.
module tb_reaction_timer_fsm;

  localparam int P  = 16;
  localparam int HZ = 5;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] led;
    logic [15:0] bcd;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  reaction_timer_fsm_if bif ();

  reaction_timer_fsm #(
    .PREP_CYCLES (P),
    .HZ_DIV      (HZ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fast stand-in for the 1 kHz wave: rises on every cyc%4==0.
  initial begin
    cyc      = 0;
    bif.dclk = 1'b0;
    forever begin
      @(negedge clk);
      cyc      = cyc + 1;
      bif.dclk = ((cyc % 4) < 2);
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ms ticks counted = dclk rises driven in [lo, hi).
  function automatic int rises(input int lo, input int hi);
    int n;
    n = 0;
    for (int c = lo; c < hi; c++)
      if (c % 4 == 0) n++;
    return n;
  endfunction

  function automatic logic [15:0] bcd_now();
    return {bif.counter_d, bif.counter_c,
            bif.counter_b, bif.counter_a};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wait_mod(input int m);
    do step(); while (cyc % 4 != m);
  endtask

  task automatic push(input logic [3:0] st,
                      input logic [15:0] led,
                      input logic [15:0] bcd);
    exp_t e;
    e.st  = st;
    e.led = led;
    e.bcd = bcd;
    exp_q.push_back(e);
  endtask

  // Start press aligned so the prep window edges fall between ticks.
  task automatic start_prep(output int ns, input bit hold);
    wait_mod(1);
    ns = cyc;
    bif.idletoPrep = 1'b1;
    push(4'd1, 16'h0000, 16'h0000);
    repeat (3) step();
    bif.idletoPrep = 1'b0;
    repeat (4) step();
    if (hold) bif.idletoPrep = 1'b1;
    wait_to(ns + 9);
    chk("prep_count", 64'(bif.prepCounter), 64'd5);
    chk("prep_next", 64'(bif.nextState), 64'd1);
  endtask

  task automatic react_round(input int r);
    int ns, lo, nr;
    logic [15:0] v;
    start_prep(ns, (r == 12));
    lo = ns + P + 1;
    push(4'd2, 16'hFFFF, 16'h0000);
    nr = lo + 4 * r;
    v  = to_bcd(rises(lo, nr));
    wait_to(nr);
    bif.testmodeBtn = 1'b1;
    push(4'd3, 16'h0000, v);
    repeat (2) step();
    bif.testmodeBtn = 1'b0;
    repeat (20) step();
    chk("done_hold", 64'(bcd_now()), 64'(v));
    bif.idletoPrep = 1'b0;
    repeat (6) step();
  endtask

  task automatic early_round(input int d);
    int ns;
    start_prep(ns, 1'b0);
    if (ns + d > cyc) wait_to(ns + d);
    bif.testmodeBtn = 1'b1;
    push(4'd4, 16'hAAAA, 16'h9999);
    repeat (2) step();
    bif.testmodeBtn = 1'b0;
    repeat (20) step();
    chk("early_hold", 64'(bcd_now()), 64'h9999);
  endtask

  initial begin
    exp_t e;
    logic [3:0] prev;
    prev = 4'd0;
    forever begin
      @(negedge clk);
      if (bif.state !== prev) begin
        prev = bif.state;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: state %0d, nothing expected",
                   bif.state);
        end else begin
          e = exp_q.pop_front();
          if ({bif.state, bif.led, bcd_now()} !== e) begin
            failures++;
            $display("FAIL sb_trans: got st=%0d led=%h bcd=%h expected st=%0d led=%h bcd=%h",
                     bif.state, bif.led, bcd_now(), e.st, e.led, e.bcd);
          end
        end
      end
    end
  end

  initial begin
    int ns, p, t0, t1;
    bit got;
    logic prevh;
    logic [15:0] v;
    logic [7:0] anodes [4];
    anodes = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bif.idletoPrep  = 1'b0;
    bif.testmodeBtn = 1'b0;
    repeat (4) step();
    chk("rst_state", 64'(bif.state), 64'd0);
    chk("rst_led", 64'(bif.led), 64'd0);
    chk("rst_bcd", 64'(bcd_now()), 64'd0);
    chk("rst_prep", 64'(bif.prepCounter), 64'd0);
    chk("rst_anode", 64'(bif.ssdAnode), 64'hFE);
    chk("rst_cath", 64'(bif.ssdCathode), 64'(segtab[0]));
    chk("rst_hz", 64'(bif.clk_1Hzt), 64'd0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("idle_next", 64'(bif.nextState), 64'd0);

    react_round(12);

    // Display scan during DONE holding 12 ms.
    v = bcd_now();
    p = 4;
    for (int i = 0; i < 4; i++)
      if (bif.ssdAnode == anodes[i]) p = i;
    chk("disp_anode_valid", 64'(p < 4), 64'd1);
    if (p > 3) p = 0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) step();
      p = (p + 1) % 4;
      chk("disp_anode", 64'(bif.ssdAnode), 64'(anodes[p]));
      chk("disp_cath", 64'(bif.ssdCathode),
          64'(segtab[v[p*4 +: 4]]));
    end

    got = 0;
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      prevh = bif.clk_1Hzt;
      step();
      if (!prevh && bif.clk_1Hzt) begin got = 1; t0 = cyc; end
    end
    if (got) begin
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        prevh = bif.clk_1Hzt;
        step();
        if (!prevh && bif.clk_1Hzt) begin got = 1; t1 = cyc; end
      end
    end
    chk("hz_seen", 64'(got), 64'd1);
    chk("hz_period", 64'(t1 - t0), 64'(8 * HZ));

    for (int i = 0; i < 3; i++) begin
      early_round($urandom_range(2, P - 2));
      react_round($urandom_range(1, 300));
    end

    // Let TIMING run out to the 9999 ceiling.
    start_prep(ns, 1'b0);
    push(4'd2, 16'hFFFF, 16'h0000);
    push(4'd3, 16'h0000, 16'h9999);
    wait_to(ns + P + 4 * 10000 + 20);
    chk("timeout_hold", 64'(bcd_now()), 64'h9999);

    // Asynchronous reset in the middle of TIMING.
    start_prep(ns, 1'b0);
    push(4'd2, 16'hFFFF, 16'h0000);
    wait_to(ns + P + 1 + 28);
    push(4'd0, 16'h0000, 16'h0000);
    reset = 1'b1;
    #1;
    chk("arst_now",
        64'({bif.state, bif.led, bcd_now()}), 64'd0);
    step();
    reset = 1'b0;
    repeat (4) step();
    react_round($urandom_range(1, 60));

    repeat (20) step();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
